// File: rtl/count_sequence_tracker.sv
// Tracks position within a fixed 18-entry skip/reverse count sequence from observed digits.
// Keeps a candidate-index mask and reports lock, recovered index, step size and inconsistency.
module count_sequence_tracker #(
  parameter int SEQ_LEN = 18
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iValid,
  input  logic [3:0] iV,
  output logic [4:0] oState,
  output logic       oLocked,
  output logic [1:0] oStep,
  output logic       oStepValid,
  output logic       oErr
);

  logic [SEQ_LEN-1:0] r_cand;
  logic [SEQ_LEN-1:0] w_match;
  logic [SEQ_LEN-1:0] w_succ;
  logic [SEQ_LEN-1:0] w_next;
  logic               w_miss;
  logic               w_onehot;
  logic [4:0]         w_idx;
  logic [5:0]         w_diff;
  logic [1:0]         w_step;

  function automatic logic [3:0] f_digit(input logic [4:0] idx);
    case (idx)
      5'd0:    f_digit = 4'd7;
      5'd1:    f_digit = 4'd0;
      5'd2:    f_digit = 4'd8;
      5'd3:    f_digit = 4'd6;
      5'd4:    f_digit = 4'd5;
      5'd5:    f_digit = 4'd2;
      5'd6:    f_digit = 4'd6;
      5'd7:    f_digit = 4'd4;
      5'd8:    f_digit = 4'd7;
      5'd9:    f_digit = 4'd5;
      5'd10:   f_digit = 4'd4;
      5'd11:   f_digit = 4'd1;
      5'd12:   f_digit = 4'd2;
      5'd13:   f_digit = 4'd9;
      5'd14:   f_digit = 4'd5;
      5'd15:   f_digit = 4'd7;
      5'd16:   f_digit = 4'd8;
      5'd17:   f_digit = 4'd9;
      default: f_digit = 4'd15;
    endcase
  endfunction

  // Match mask for the observed digit and the set of reachable successors of every candidate.
  always_comb begin
    w_match = '0;
    w_succ  = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (f_digit(5'(i)) == iV) w_match[5'(i)] = 1'b1;
      if (r_cand[5'(i)]) begin
        w_succ[5'((i + 1) % SEQ_LEN)]           = 1'b1;
        w_succ[5'((i + SEQ_LEN - 1) % SEQ_LEN)] = 1'b1;
        w_succ[5'((i + 2) % SEQ_LEN)]           = 1'b1;
        w_succ[5'((i + SEQ_LEN - 2) % SEQ_LEN)] = 1'b1;
      end
    end
  end

  always_comb begin
    w_miss   = (r_cand != '0) && ((w_succ & w_match) == '0);
    w_next   = ((r_cand == '0) || w_miss) ? w_match : (w_succ & w_match);
    w_onehot = (w_next != '0) && ((w_next & (w_next - 1'b1)) == '0);
    w_idx    = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (w_next[5'(i)]) w_idx = 5'(i);
    end
  end

  // Modular index difference; successors only ever land at +-1 or +-2.
  always_comb begin
    w_diff = {1'b0, w_idx} + 6'(SEQ_LEN) - {1'b0, oState};
    if (w_diff >= 6'(SEQ_LEN)) w_diff = w_diff - 6'(SEQ_LEN);
    case (w_diff)
      6'd1:    w_step = 2'b00;
      6'd2:    w_step = 2'b10;
      6'(SEQ_LEN - 1): w_step = 2'b01;
      default: w_step = 2'b11;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cand     <= '0;
      oState     <= '0;
      oLocked    <= 1'b0;
      oStep      <= 2'b00;
      oStepValid <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      oStepValid <= 1'b0;
      oErr       <= 1'b0;
      if (iValid) begin
        r_cand  <= w_next;
        oLocked <= w_onehot;
        oErr    <= w_miss;
        if (w_onehot) oState <= w_idx;
        if (oLocked && w_onehot && !w_miss) begin
          oStepValid <= 1'b1;
          oStep      <= w_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_tracker.sv
// Scoreboard bench for count_sequence_tracker: a behavioural model predicts each cycle's outputs.
module tb_count_sequence_tracker;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iValid;
  logic [3:0] iV;
  logic [4:0] oState;
  logic       oLocked;
  logic [1:0] oStep;
  logic       oStepValid;
  logic       oErr;

  count_sequence_tracker #(.SEQ_LEN(18)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iV(iV),
    .oState(oState), .oLocked(oLocked), .oStep(oStep),
    .oStepValid(oStepValid), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [4:0] st;
    logic       lk;
    logic [1:0] stp;
    logic       sv;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   seq_tab[18] = '{7, 0, 8, 6, 5, 2, 6, 4, 7, 5, 4, 1, 2, 9, 5, 7, 8, 9};
  logic [17:0] m_cand;
  logic [4:0]  m_state;
  logic        m_locked;
  logic [1:0]  m_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_cand   = '0;
    m_state  = '0;
    m_locked = 1'b0;
    m_step   = 2'b00;
  endtask

  // Predict the registered outputs produced by one cycle of stimulus and queue them.
  task automatic model_push(input logic vld, input logic [3:0] v);
    logic [17:0] match, succ, nxt;
    logic        err, sv;
    int          ni, d;
    exp_t        e;
    err = 1'b0;
    sv  = 1'b0;
    if (vld) begin
      match = '0;
      succ  = '0;
      for (int i = 0; i < 18; i++) begin
        if (seq_tab[i] == int'(v)) match[i] = 1'b1;
        if (m_cand[i]) begin
          succ[(i + 1) % 18]  = 1'b1;
          succ[(i + 17) % 18] = 1'b1;
          succ[(i + 2) % 18]  = 1'b1;
          succ[(i + 16) % 18] = 1'b1;
        end
      end
      if (m_cand == 0) nxt = match;
      else begin
        nxt = succ & match;
        if (nxt == 0) begin
          nxt = match;
          err = 1'b1;
        end
      end
      ni = -1;
      if ($countones(nxt) == 1)
        for (int i = 0; i < 18; i++) if (nxt[i]) ni = i;
      if (m_locked && ni >= 0 && !err) begin
        sv = 1'b1;
        d  = (ni - int'(m_state) + 18) % 18;
        case (d)
          1:       m_step = 2'b00;
          17:      m_step = 2'b01;
          2:       m_step = 2'b10;
          default: m_step = 2'b11;
        endcase
      end
      m_cand   = nxt;
      m_locked = (ni >= 0);
      if (ni >= 0) m_state = 5'(ni);
    end
    e.st  = m_state;
    e.lk  = m_locked;
    e.stp = m_step;
    e.sv  = sv;
    e.er  = err;
    exp_q.push_back(e);
  endtask

  // Called just after a falling edge: drive, clock once, compare on the next falling edge.
  task automatic cyc(input logic vld, input logic [3:0] v);
    exp_t e;
    iValid = vld;
    iV     = v;
    model_push(vld, v);
    @(posedge iClk);
    @(negedge iClk);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("state", 32'(oState), 32'(e.st));
      chk("locked", 32'(oLocked), 32'(e.lk));
      chk("step", 32'(oStep), 32'(e.stp));
      chk("stepvalid", 32'(oStepValid), 32'(e.sv));
      chk("err", 32'(oErr), 32'(e.er));
    end
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRst   = 1'b0;
    iValid = 1'b0;
    iV     = 4'd0;
    model_reset();
    @(negedge iClk);
    do_reset();
    chk("rst_locked", 32'(oLocked), 32'd0);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_sv", 32'(oStepValid), 32'd0);
    chk("rst_err", 32'(oErr), 32'd0);

    // Acquire and forward, then skip reverse, then wrap (first 0 is inconsistent from index 1).
    cyc(1, 4'd0); cyc(1, 4'd8); cyc(1, 4'd6);
    cyc(1, 4'd0);
    cyc(1, 4'd0); cyc(1, 4'd7); cyc(1, 4'd9);
    chk("wrap_state", 32'(oState), 32'd17);
    chk("wrap_step", 32'(oStep), 32'd1);

    // Ambiguity then relock, then an out-of-table digit and recovery.
    do_reset();
    cyc(1, 4'd1); cyc(1, 4'd9); cyc(1, 4'd7);
    cyc(1, 4'd9);
    chk("ambig_locked", 32'(oLocked), 32'd0);
    chk("ambig_state", 32'(oState), 32'd15);
    cyc(1, 4'd1);
    chk("relock_state", 32'(oState), 32'd11);
    cyc(1, 4'd3);
    chk("err_locked", 32'(oLocked), 32'd0);
    cyc(1, 4'd0);
    chk("recover_state", 32'(oState), 32'd1);

    // Idle hold while locked, then asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cyc(0, 4'd5);
    #2;
    iRst   = 1'b1;
    iValid = 1'b1;
    iV     = 4'd8;
    #1;
    chk("async_locked", 32'(oLocked), 32'd0);
    chk("async_state", 32'(oState), 32'd0);
    @(posedge iClk);
    @(negedge iClk);
    chk("rst_nosample", 32'(oLocked), 32'd0);
    iRst = 1'b0;
    model_reset();
    exp_q.delete();
    cyc(1, 4'd8);
    chk("post_rst_search", 32'(oLocked), 32'd0);

    // Random walks along the sequence with occasional idles and stray digits.
    for (int r = 0; r < 3; r++) begin
      int pos;
      pos = $urandom_range(0, 17);
      do_reset();
      for (int k = 0; k < 40; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) cyc(0, 4'($urandom_range(0, 15)));
        else if (sel == 1) cyc(1, 4'($urandom_range(0, 15)));
        else begin
          case ($urandom_range(0, 3))
            0: pos = (pos + 1) % 18;
            1: pos = (pos + 17) % 18;
            2: pos = (pos + 2) % 18;
            default: pos = (pos + 16) % 18;
          endcase
          cyc(1, 4'(seq_tab[pos]));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
